pe_operand_collector: RTL

PE_OPERAND_COLLECTOR -- requirements
Module: pe_operand_collector

---
 rtl/pe_operand_collector_pkg.sv | 30 +++
 rtl/opcoll_slot.sv | 61 ++++++
 rtl/pe_operand_collector.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/pe_operand_collector_pkg.sv
// Shared types and constants for the PE operand collector: source selects,
// FSM states and neighbour port indices.
package pe_operand_collector_pkg;

  typedef enum logic [2:0] {
    SRC_N     = 3'd0,
    SRC_E     = 3'd1,
    SRC_S     = 3'd2,
    SRC_W     = 3'd3,
    SRC_CONST = 3'd4,
    SRC_NONE  = 3'd5
  } src_sel_e;

  typedef enum logic {
    StCollect = 1'b0,
    StIssue   = 1'b1
  } opcoll_state_e;

  localparam int unsigned PortN    = 0;
  localparam int unsigned PortE    = 1;
  localparam int unsigned PortS    = 2;
  localparam int unsigned PortW    = 3;
  localparam int unsigned NumPorts = 4;

  // Encodings above SRC_CONST all mean the slot is not used.
  function automatic logic src_is_used(input logic [2:0] sel);
    return sel <= SRC_CONST;
  endfunction

endpackage

// File: rtl/opcoll_slot.sv
// One operand slot: selects its source, captures a tagged token or the
// constant into a holding register and tracks the full flag.
module opcoll_slot
  import pe_operand_collector_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [2:0]                         sel_i,
  input  logic [NumPorts-1:0][DATA_WIDTH:0]  port_tok_i,
  input  logic [DATA_WIDTH-1:0]              const_i,
  input  logic                               capture_en_i,
  input  logic                               clear_i,
  output logic                               full_o,
  output logic [DATA_WIDTH-1:0]              data_o,
  output logic [NumPorts-1:0]                take_o
);

  logic                  full_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  src_valid;
  logic [DATA_WIDTH-1:0] src_data;
  logic [NumPorts-1:0]   src_port;
  logic                  capture;

  always_comb begin
    src_valid = 1'b0;
    src_data  = '0;
    src_port  = '0;
    case (sel_i)
      SRC_N, SRC_E, SRC_S, SRC_W: begin
        src_valid             = port_tok_i[sel_i[1:0]][DATA_WIDTH];
        src_data              = port_tok_i[sel_i[1:0]][DATA_WIDTH-1:0];
        src_port[sel_i[1:0]] = 1'b1;
      end
      SRC_CONST: begin
        src_valid = 1'b1;
        src_data  = const_i;
      end
      default: ;
    endcase
  end

  assign capture = capture_en_i & src_is_used(sel_i) & ~full_q & src_valid;
  assign take_o  = capture ? src_port : '0;

  always_ff @(posedge clk) begin
    if (reset || clear_i) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else if (capture) begin
      full_q <= 1'b1;
      data_q <= src_data;
    end
  end

  assign full_o = full_q;
  assign data_o = data_q;

endmodule

// File: rtl/pe_operand_collector.sv
// Collects up to three tagged operands from N/E/S/W neighbours or a constant and
// issues them to the ALU. Define OPCOLL_TIMEOUT_EN to abandon stuck partial collections.
module pe_operand_collector
  import pe_operand_collector_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH:0]   in_n,
  input  logic [DATA_WIDTH:0]   in_e,
  input  logic [DATA_WIDTH:0]   in_s,
  input  logic [DATA_WIDTH:0]   in_w,
  output logic [3:0]            in_ack,
  input  logic [2:0]            cfg_lhs_sel,
  input  logic [2:0]            cfg_rhs_sel,
  input  logic [2:0]            cfg_shift_sel,
  input  logic [5:0]            cfg_operation,
  input  logic [DATA_WIDTH-1:0] cfg_const,
  output logic [DATA_WIDTH:0]   op_LHS,
  output logic [DATA_WIDTH:0]   op_RHS,
  output logic [DATA_WIDTH:0]   op_SHIFT,
  output logic [5:0]            operation,
  output logic                  issue_valid,
  input  logic                  issue_ready,
  output logic                  err_timeout
);

  localparam int unsigned NumSlots = 3;

  opcoll_state_e                      state_q, state_d;
  logic                               cfg_latched_q;
  logic [NumSlots-1:0][2:0]           sel_q, sel_in, sel_eff;
  logic [5:0]                         opcode_q;
  logic [NumPorts-1:0][DATA_WIDTH:0]  port_tok;
  logic [NumSlots-1:0]                slot_full;
  logic [NumSlots-1:0][DATA_WIDTH-1:0] slot_data;
  logic [NumSlots-1:0][NumPorts-1:0]  slot_take;
  logic all_empty, all_used_full, done, latch, capture_en;
  logic issue_fire, timeout_fire, slot_clear;

  always_comb begin
    port_tok        = '0;
    port_tok[PortN] = in_n;
    port_tok[PortE] = in_e;
    port_tok[PortS] = in_s;
    port_tok[PortW] = in_w;
  end

  assign sel_in    = {cfg_shift_sel, cfg_rhs_sel, cfg_lhs_sel};
  assign all_empty = ~|slot_full;

  always_comb begin
    all_used_full = 1'b1;
    for (int i = 0; i < NumSlots; i++) begin
      if (src_is_used(sel_q[i]) && !slot_full[i]) all_used_full = 1'b0;
    end
  end

  // cfg_latched_q lets a configuration with no used slots still issue once.
  assign done       = (state_q == StCollect) && cfg_latched_q && all_used_full;
  assign latch      = (state_q == StCollect) && all_empty && !done;
  // Captures in the latch cycle already follow the incoming configuration.
  assign sel_eff    = latch ? sel_in : sel_q;
  assign capture_en = (state_q == StCollect) && !done && !timeout_fire;
  assign issue_fire = (state_q == StIssue) && issue_ready;
  assign slot_clear = issue_fire | timeout_fire;

  for (genvar i = 0; i < NumSlots; i++) begin : g_slot
    opcoll_slot #(
      .DATA_WIDTH(DATA_WIDTH)
    ) u_slot (
      .clk          (clk),
      .reset        (reset),
      .sel_i        (sel_eff[i]),
      .port_tok_i   (port_tok),
      .const_i      (cfg_const),
      .capture_en_i (capture_en),
      .clear_i      (slot_clear),
      .full_o       (slot_full[i]),
      .data_o       (slot_data[i]),
      .take_o       (slot_take[i])
    );
  end

  // Ack is combinational: the token is consumed on the same edge it is captured.
  always_comb begin
    in_ack = '0;
    for (int i = 0; i < NumSlots; i++) in_ack |= slot_take[i];
    if (reset) in_ack = '0;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StCollect: if (done) state_d = StIssue;
      StIssue:   if (issue_ready) state_d = StCollect;
      default:   state_d = StCollect;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StCollect;
      cfg_latched_q <= 1'b0;
      sel_q         <= {NumSlots{3'(SRC_NONE)}};
      opcode_q      <= '0;
    end else begin
      state_q <= state_d;
      if (latch) begin
        cfg_latched_q <= 1'b1;
        sel_q         <= sel_in;
        opcode_q      <= cfg_operation;
      end else if (slot_clear) begin
        cfg_latched_q <= 1'b0;
      end
    end
  end

  assign issue_valid = (state_q == StIssue);
  assign op_LHS      = issue_valid ? {slot_full[0], slot_data[0]} : '0;
  assign op_RHS      = issue_valid ? {slot_full[1], slot_data[1]} : '0;
  assign op_SHIFT    = issue_valid ? {slot_full[2], slot_data[2]} : '0;
  assign operation   = issue_valid ? opcode_q : '0;

`ifdef OPCOLL_TIMEOUT_EN
  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CntW-1:0] tmo_cnt_q;
  logic            err_q;
  logic            partial;

  assign partial      = (state_q == StCollect) && !all_empty && !all_used_full;
  assign timeout_fire = partial && (tmo_cnt_q == CntW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      if (!partial || timeout_fire) tmo_cnt_q <= '0;
      else                          tmo_cnt_q <= tmo_cnt_q + 1'b1;
      if (timeout_fire) err_q <= 1'b1;
    end
  end

  assign err_timeout = err_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout_fire       = 1'b0;
  assign err_timeout        = 1'b0;
`endif

endmodule
